r_id_restore_unit: RTL and testbench
====================================

R_ID_RESTORE_UNIT -- requirements
Module: r_id_restore_unit

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, giving the width of the unique and original IDs.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the R data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port r_in, r_if.receiver: R beats from the slave, carrying valid, id (unique ID), data, resp[1:0], last and tagid; ready is an output.
REQ-006 SHALL have port r_out, r_if.sender: R beats to the master, carrying valid, id (original ID), data, resp, last and tagid; ready is an input.
REQ-007 SHALL have port lookup_req, output, 1 bit: request translation of lookup_uid.
REQ-008 SHALL have port lookup_uid, output, ID_WIDTH: unique ID to translate.
REQ-009 SHALL have ports lookup_ack (input, 1 bit), lookup_hit (input, 1 bit) and lookup_orig_id (input, ID_WIDTH): the tag-map reply.
REQ-010 SHALL have ports free_valid (output, 1 bit) and free_uid (output, ID_WIDTH): a one-cycle release pulse for a unique ID.
REQ-011 SHALL have ports err_miss and err_interleave, output, 1 bit each: sticky error flags.
REQ-012 SHALL have port beat_cnt, output, 8 bits: count of r_out beats in the current burst.

Function
REQ-013 SHALL implement states S_IDLE, S_LOOK and S_STRM, plus a single-beat holding buffer (buf_v, data, resp, last) and registers uid_q, orig_q and miss_q.
REQ-014 In S_IDLE: r_in.ready=1; on r_in handshake, capture the beat into the buffer (buf_v<=1), set uid_q<=r_in.id, and go to S_LOOK.
REQ-015 In S_LOOK: r_in.ready=0, lookup_req=1, lookup_uid=uid_q (lookup_uid is uid_q in all states).
REQ-016 On lookup_ack in S_LOOK: orig_q<=lookup_hit?lookup_orig_id:uid_q; miss_q<=~lookup_hit; err_miss<=1 if ~lookup_hit; go to S_STRM.
REQ-017 In S_STRM: r_out.valid=buf_v; r_in.ready=(~buf_v | r_out.ready) & ~(buf_v & buf_last).
REQ-018 In S_STRM, a simultaneous r_out handshake and r_in handshake SHALL replace the buffer in the same cycle, giving 1 beat/cycle throughput.
REQ-019 r_out.valid SHALL be 0 in S_IDLE and S_LOOK.
REQ-020 r_out.id=orig_q; r_out.tagid=uid_q; r_out.data and r_out.last come from the buffer.
REQ-021 r_out.resp=2'b10 (SLVERR) when miss_q=1, else the buffered resp.
REQ-022 A beat accepted in S_STRM with r_in.id != uid_q SHALL set err_interleave and be forwarded unchanged, under orig_q.
REQ-023 On an r_out handshake with buf_last=1: free_valid=1 (combinational, that cycle), free_uid=uid_q, buf_v<=0, next state S_IDLE.
REQ-024 free_valid SHALL be 0 in every other cycle.
REQ-025 beat_cnt SHALL increment on each r_out handshake, wrap 255->0, and clear to 0 on the handshake of the last beat.
REQ-026 Latency: a beat accepted in cycle N with lookup_ack=1 in cycle N+1 SHALL give r_out.valid=1 in cycle N+2.
REQ-027 While the tag map withholds lookup_ack, the block SHALL stay in S_LOOK indefinitely with the beat held.
REQ-028 r_out fields SHALL stay stable while r_out.valid=1 and r_out.ready=0.
REQ-029 err_miss and err_interleave SHALL be cleared only by reset.
REQ-030 SHALL use bitwise operators only (& | ~).

Reset
REQ-031 While rst=0: state S_IDLE, buf_v=0, uid_q=orig_q=0, miss_q=0, beat_cnt=0, err flags 0, r_out.valid=0, lookup_req=0, free_valid=0; no beat captured.
REQ-032 Reset mid-burst SHALL drop the held beat with no free_valid pulse; r_in.ready=1 in the first cycle after release.

Verification
REQ-033 Single beat uid=3, ack+hit with orig 9 in the next cycle -> r_out id=9, tagid=3, last=1 two cycles after accept; free_valid=1 with free_uid=3 on that handshake.
REQ-034 4-beat burst uid=5, r_out.ready=1 throughout -> 4 consecutive r_out beats, beat_cnt 0,1,2,3, then 0; exactly one free pulse, on beat 4.
REQ-035 lookup_ack held 0 for 10 cycles -> lookup_req=1 and r_in.ready=0 throughout; no r_out.valid until 1 cycle after ack.
REQ-036 Miss (ack=1, hit=0) on uid=7, resp=2'b00 -> r_out id=7, resp=2'b10, err_miss=1 stays set after the burst.
REQ-037 r_out.ready toggled 1,0,0,1 mid-burst -> r_out fields stable while stalled; no beat lost or duplicated.
REQ-038 Mid-burst beat with id 2 while uid_q=5; then rst=0 asserted mid-burst -> err_interleave=1; after reset all outputs at reset values and no free pulse.

Source files
------------

// File: rtl/r_id_restore_unit_if.sv
// r_if: AXI-style R channel bundle shared by the ID restore unit and its
// neighbours.
//   valid/ready : handshake pair
//   id          : transaction ID (unique ID toward the slave, original toward the master)
//   data        : read data beat
//   resp        : read response code
//   last        : final beat of a burst
//   tagid       : unique (tag) ID carried alongside the beat
// modport receiver : consumes beats (drives ready)
// modport sender   : produces beats (samples ready)
interface r_if #(
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [ID_WIDTH-1:0]   id;
   logic [DATA_WIDTH-1:0] data;
   logic [1:0]            resp;
   logic                  last;
   logic [ID_WIDTH-1:0]   tagid;

   modport receiver (
      input  valid, id, data, resp, last, tagid,
      output ready
   );

   modport sender (
      output valid, id, data, resp, last, tagid,
      input  ready
   );
endinterface

// File: rtl/r_id_restore_unit.sv
// r_id_restore_unit: restores the master's original ID on R beats returning
// from the slave under a unique ID. The first beat of a burst is parked in a
// single-beat buffer while the tag map is queried; the rest of the burst then
// streams through the buffer at one beat per cycle, and the unique ID is
// released when the last beat leaves.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   r_in           : R beats from the slave (unique IDs)
//   r_out          : R beats to the master (original IDs, tagid = unique ID)
//   lookup_req     : tag-map translation request for lookup_uid
//   lookup_uid     : unique ID being translated (always the captured ID)
//   lookup_ack     : tag-map reply strobe
//   lookup_hit     : tag-map reply found a mapping
//   lookup_orig_id : original ID returned by the tag map
//   free_valid     : one-cycle release pulse for free_uid
//   free_uid       : unique ID being released
//   err_miss       : sticky, a lookup missed
//   err_interleave : sticky, a foreign ID arrived inside a burst
//   beat_cnt       : r_out beats delivered so far in the current burst
module r_id_restore_unit #(
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   r_if.receiver               r_in,
   r_if.sender                 r_out,
   output logic                lookup_req,
   output logic [ID_WIDTH-1:0] lookup_uid,
   input  logic                lookup_ack,
   input  logic                lookup_hit,
   input  logic [ID_WIDTH-1:0] lookup_orig_id,
   output logic                free_valid,
   output logic [ID_WIDTH-1:0] free_uid,
   output logic                err_miss,
   output logic                err_interleave,
   output logic [7:0]          beat_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOK,
      S_STRM
   } state_t;

   state_t state, state_nx;

   logic                  buf_v;
   logic [DATA_WIDTH-1:0] buf_data;
   logic [1:0]            buf_resp;
   logic                  buf_last;
   logic [ID_WIDTH-1:0]   uid_q;
   logic [ID_WIDTH-1:0]   orig_q;
   logic                  miss_q;

   logic in_ready;
   logic out_valid;
   logic in_hs;
   logic out_hs;
   logic id_mismatch;

   assign in_hs       = r_in.valid & in_ready;
   assign out_hs      = out_valid & r_out.ready;
   assign id_mismatch = |(r_in.id ^ uid_q);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (~rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (in_hs) state_nx = S_LOOK;
         S_LOOK:  if (lookup_ack) state_nx = S_STRM;
         S_STRM:  if (out_hs & buf_last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output logic. In S_STRM a stalled last beat blocks intake so the next
   // burst's first beat is always captured from S_IDLE.
   always_comb begin
      in_ready   = 1'b0;
      lookup_req = 1'b0;
      out_valid  = 1'b0;
      case (state)
         S_IDLE: in_ready = 1'b1;
         S_LOOK: lookup_req = 1'b1;
         S_STRM: begin
            out_valid = buf_v;
            in_ready  = (~buf_v | r_out.ready) & ~(buf_v & buf_last);
         end
         default: ;
      endcase
   end

   assign free_valid = out_hs & buf_last;
   assign free_uid   = uid_q;
   assign lookup_uid = uid_q;
   assign r_in.ready = in_ready;

   assign r_out.valid = out_valid;
   assign r_out.id    = orig_q;
   assign r_out.tagid = uid_q;
   assign r_out.data  = buf_data;
   assign r_out.last  = buf_last;
   assign r_out.resp  = ({2{miss_q}} & 2'b10) | ({2{~miss_q}} & buf_resp);

   // Datapath: holding buffer, captured IDs, sticky errors, beat counter.
   // An intake handshake takes priority over the drain so a simultaneous
   // in/out handshake refills the buffer in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (~rst) begin
         buf_v          <= 1'b0;
         buf_data       <= '0;
         buf_resp       <= '0;
         buf_last       <= 1'b0;
         uid_q          <= '0;
         orig_q         <= '0;
         miss_q         <= 1'b0;
         err_miss       <= 1'b0;
         err_interleave <= 1'b0;
         beat_cnt       <= '0;
      end else begin
         if (in_hs) begin
            buf_v    <= 1'b1;
            buf_data <= r_in.data;
            buf_resp <= r_in.resp;
            buf_last <= r_in.last;
            if (state == S_IDLE) uid_q <= r_in.id;
            if ((state == S_STRM) & id_mismatch) err_interleave <= 1'b1;
         end else if (out_hs) begin
            buf_v <= 1'b0;
         end

         if (lookup_req & lookup_ack) begin
            orig_q <= lookup_hit ? lookup_orig_id : uid_q;
            miss_q <= ~lookup_hit;
            if (~lookup_hit) err_miss <= 1'b1;
         end

         if (out_hs) begin
            if (buf_last) beat_cnt <= '0;
            else          beat_cnt <= beat_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_r_id_restore_unit.sv
// Directed bench for r_id_restore_unit: inputs change on the falling edge,
// outputs are compared 1 time unit later, state advances on the rising edge.
module tb_r_id_restore_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   r_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) rin ();
   r_if #(.ID_WIDTH(4), .DATA_WIDTH(32)) rout ();

   logic       lookup_req;
   logic [3:0] lookup_uid;
   logic       lookup_ack;
   logic       lookup_hit;
   logic [3:0] lookup_orig_id;
   logic       free_valid;
   logic [3:0] free_uid;
   logic       err_miss;
   logic       err_interleave;
   logic [7:0] beat_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   r_id_restore_unit #(.ID_WIDTH(4), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .r_in           (rin),
      .r_out          (rout),
      .lookup_req     (lookup_req),
      .lookup_uid     (lookup_uid),
      .lookup_ack     (lookup_ack),
      .lookup_hit     (lookup_hit),
      .lookup_orig_id (lookup_orig_id),
      .free_valid     (free_valid),
      .free_uid       (free_uid),
      .err_miss       (err_miss),
      .err_interleave (err_interleave),
      .beat_cnt       (beat_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive_beat(input logic v, input logic [3:0] id, input logic [31:0] data,
                             input logic [1:0] resp, input logic last);
      rin.valid = v;
      rin.id    = id;
      rin.data  = data;
      rin.resp  = resp;
      rin.last  = last;
   endtask

   // Accept a first beat from S_IDLE, hold off the tag map for 'stall'
   // cycles, then ack. Returns at the falling edge of the first S_STRM cycle.
   task automatic start_burst(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                              input logic last, input logic hit, input logic [3:0] orig, input int stall);
      @(negedge clk);
      rout.ready = 1'b0;
      lookup_ack = 1'b0;
      drive_beat(1'b1, id, data, resp, last);
      #1 check("accept_ready", rin.ready, 1'b1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         drive_beat(1'b1, id, 32'hDEAD_BEEF, 2'b11, 1'b0);
         #1;
         check("stall_lookup_req", lookup_req, 1'b1);
         check("stall_in_ready", rin.ready, 1'b0);
         check("stall_out_valid", rout.valid, 1'b0);
      end
      @(negedge clk);
      drive_beat(1'b0, 4'h0, 32'h0, 2'b00, 1'b0);
      lookup_ack     = 1'b1;
      lookup_hit     = hit;
      lookup_orig_id = orig;
      #1;
      check("look_req", lookup_req, 1'b1);
      check("look_uid", lookup_uid, id);
      check("look_out_valid", rout.valid, 1'b0);
      check("look_in_ready", rin.ready, 1'b0);
      @(negedge clk);
      lookup_ack = 1'b0;
   endtask

   // Stall-pattern table for the ready-toggle burst
   logic        t5_rdy   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic        t5_inv   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [31:0] t5_indat [5] = '{32'd201, 32'd202, 32'd202, 32'd202, 32'd0};
   logic        t5_inlst [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [31:0] t5_data  [5] = '{32'd200, 32'd201, 32'd201, 32'd201, 32'd202};
   logic [7:0]  t5_cnt   [5] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
   logic        t5_free  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        t5_inrdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      drive_beat(1'b0, 4'h0, 32'h0, 2'b00, 1'b0);
      rin.tagid      = 4'h0;
      rout.ready     = 1'b0;
      lookup_ack     = 1'b0;
      lookup_hit     = 1'b0;
      lookup_orig_id = 4'h0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_out_valid", rout.valid, 1'b0);
      check("rst_lookup_req", lookup_req, 1'b0);
      check("rst_free_valid", free_valid, 1'b0);
      check("rst_beat_cnt", beat_cnt, 8'd0);
      check("rst_err_miss", err_miss, 1'b0);
      check("rst_err_il", err_interleave, 1'b0);
      check("rst_lookup_uid", lookup_uid, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("post_rst_in_ready", rin.ready, 1'b1);

      // Single beat, uid 3 -> orig 9
      start_burst(4'h3, 32'hA5A5_0001, 2'b00, 1'b1, 1'b1, 4'h9, 0);
      rout.ready = 1'b1;
      #1;
      check("t1_valid", rout.valid, 1'b1);
      check("t1_id", rout.id, 4'h9);
      check("t1_tagid", rout.tagid, 4'h3);
      check("t1_last", rout.last, 1'b1);
      check("t1_data", rout.data, 32'hA5A5_0001);
      check("t1_resp", rout.resp, 2'b00);
      check("t1_free", free_valid, 1'b1);
      check("t1_free_uid", free_uid, 4'h3);
      check("t1_cnt", beat_cnt, 8'd0);
      @(negedge clk);
      #1;
      check("t1_idle_valid", rout.valid, 1'b0);
      check("t1_idle_free", free_valid, 1'b0);
      check("t1_idle_ready", rin.ready, 1'b1);

      // 4-beat burst, uid 5, ready held high
      start_burst(4'h5, 32'd100, 2'b00, 1'b0, 1'b1, 4'h1, 0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         rout.ready = 1'b1;
         if (i < 3) drive_beat(1'b1, 4'h5, 32'd101 + i, 2'b00, i == 2);
         else       drive_beat(1'b0, 4'h0, 32'h0, 2'b00, 1'b0);
         #1;
         check("t2_valid", rout.valid, 1'b1);
         check("t2_data", rout.data, 32'd100 + i);
         check("t2_cnt", beat_cnt, i);
         check("t2_free", free_valid, i == 3);
         check("t2_last", rout.last, i == 3);
      end
      @(negedge clk);
      #1;
      check("t2_end_valid", rout.valid, 1'b0);
      check("t2_end_cnt", beat_cnt, 8'd0);
      check("t2_end_free", free_valid, 1'b0);

      // Tag map withholds ack for 10 cycles
      start_burst(4'h6, 32'h0000_0C0C, 2'b00, 1'b1, 1'b1, 4'hC, 10);
      rout.ready = 1'b1;
      #1;
      check("t3_valid", rout.valid, 1'b1);
      check("t3_data", rout.data, 32'h0000_0C0C);
      check("t3_id", rout.id, 4'hC);
      check("t3_free", free_valid, 1'b1);
      @(negedge clk);
      #1 check("t3_idle_valid", rout.valid, 1'b0);

      // Lookup miss on uid 7
      start_burst(4'h7, 32'h0000_0077, 2'b00, 1'b1, 1'b0, 4'hF, 0);
      rout.ready = 1'b1;
      #1;
      check("t4_id", rout.id, 4'h7);
      check("t4_tagid", rout.tagid, 4'h7);
      check("t4_resp", rout.resp, 2'b10);
      check("t4_err_miss", err_miss, 1'b1);
      check("t4_free", free_valid, 1'b1);
      @(negedge clk);
      #1;
      check("t4_err_miss_sticky", err_miss, 1'b1);
      check("t4_idle_valid", rout.valid, 1'b0);

      // Ready toggled 1,0,0,1 mid-burst
      start_burst(4'h4, 32'd200, 2'b01, 1'b0, 1'b1, 4'h2, 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         rout.ready = t5_rdy[i];
         drive_beat(t5_inv[i], 4'h4, t5_indat[i], 2'b01, t5_inlst[i]);
         #1;
         check("t5_valid", rout.valid, 1'b1);
         check("t5_data", rout.data, t5_data[i]);
         check("t5_cnt", beat_cnt, t5_cnt[i]);
         check("t5_free", free_valid, t5_free[i]);
         check("t5_in_ready", rin.ready, t5_inrdy[i]);
         check("t5_id", rout.id, 4'h2);
         check("t5_resp", rout.resp, 2'b01);
      end
      @(negedge clk);
      drive_beat(1'b0, 4'h0, 32'h0, 2'b00, 1'b0);
      #1;
      check("t5_end_valid", rout.valid, 1'b0);
      check("t5_end_cnt", beat_cnt, 8'd0);
      check("t5_err_miss", err_miss, 1'b1);

      // Interleaved ID inside burst, then reset mid-burst
      start_burst(4'h5, 32'd300, 2'b00, 1'b0, 1'b1, 4'h8, 0);
      rout.ready = 1'b1;
      drive_beat(1'b1, 4'h2, 32'd301, 2'b00, 1'b0);
      #1;
      check("t6_data0", rout.data, 32'd300);
      check("t6_il_before", err_interleave, 1'b0);
      @(negedge clk);
      drive_beat(1'b0, 4'h0, 32'h0, 2'b00, 1'b0);
      #1;
      check("t6_data1", rout.data, 32'd301);
      check("t6_id1", rout.id, 4'h8);
      check("t6_tagid1", rout.tagid, 4'h5);
      check("t6_il", err_interleave, 1'b1);
      check("t6_cnt1", beat_cnt, 8'd1);
      @(negedge clk);
      rout.ready = 1'b0;
      drive_beat(1'b1, 4'h5, 32'd302, 2'b00, 1'b0);
      #1;
      check("t6_empty_valid", rout.valid, 1'b0);
      check("t6_empty_ready", rin.ready, 1'b1);
      @(negedge clk);
      drive_beat(1'b0, 4'h0, 32'h0, 2'b00, 1'b0);
      #1;
      check("t6_held_valid", rout.valid, 1'b1);
      check("t6_held_data", rout.data, 32'd302);
      check("t6_held_cnt", beat_cnt, 8'd2);
      rst = 1'b0;
      #1;
      check("t6_rst_valid", rout.valid, 1'b0);
      check("t6_rst_free", free_valid, 1'b0);
      check("t6_rst_il", err_interleave, 1'b0);
      check("t6_rst_miss", err_miss, 1'b0);
      check("t6_rst_cnt", beat_cnt, 8'd0);
      check("t6_rst_lookup_req", lookup_req, 1'b0);
      check("t6_rst_lookup_uid", lookup_uid, 4'h0);
      @(negedge clk);
      drive_beat(1'b1, 4'h9, 32'd999, 2'b00, 1'b1);
      #1 check("t6_in_rst_valid", rout.valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      drive_beat(1'b0, 4'h0, 32'h0, 2'b00, 1'b0);
      #1;
      check("t6_rel_ready", rin.ready, 1'b1);
      check("t6_rel_lookup_req", lookup_req, 1'b0);
      check("t6_rel_free", free_valid, 1'b0);
      @(negedge clk);
      #1 check("t6_rel2_lookup_req", lookup_req, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
